// File: rtl/reg_bank_arbiter.sv
// Round-robin arbiter sharing a single-port synchronous-read register bank
// between NREQ requesters, with LOCK-based atomic bursts and a lock timeout.
module reg_bank_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned AW       = 7,
  parameter int unsigned DW       = 16,
  parameter int unsigned LOCK_MAX = 64
) (
  input  logic               SYS_CLK,
  input  logic               SYS_RST_N,
  input  logic [NREQ-1:0]    REQ,
  input  logic [NREQ-1:0]    REQ_WE,
  input  logic [NREQ-1:0]    LOCK,
  input  logic [NREQ*AW-1:0] REQ_ADDR,
  input  logic [NREQ*DW-1:0] REQ_WDATA,
  output logic [NREQ-1:0]    GNT,
  output logic [NREQ-1:0]    ACK,
  output logic [DW-1:0]      RDATA,
  output logic               LOCK_ERR,
  output logic [AW-1:0]      BANK_ADDR,
  output logic [DW-1:0]      BANK_WDATA,
  output logic               BANK_WE,
  input  logic [DW-1:0]      BANK_RDATA
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_GRANT = 3'd1;
  localparam logic [2:0] S_CAPT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_HOLD  = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            lock_err_q, lock_err_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            we_q, we_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   scan_idx;
  int unsigned     scan;
  logic [IW-1:0]   sel;
  logic [AW-1:0]   ld_addr;
  logic [DW-1:0]   ld_wdata;

  // Round-robin scan starting just after the last winner, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan      = 0;
    scan_idx  = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      scan     = (32'(last_q) + i) % NREQ;
      scan_idx = IW'(scan);
      if (!win_found && REQ[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    sel      = (state_q == S_IDLE) ? win_idx : owner_q;
    ld_addr  = REQ_ADDR[32'(sel)*AW +: AW];
    ld_wdata = REQ_WDATA[32'(sel)*DW +: DW];
  end

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    lock_err_d = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    last_d     = last_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d         = win_idx;
          gnt_d           = '0;
          gnt_d[win_idx]  = 1'b1;
          addr_d          = ld_addr;
          wdata_d         = ld_wdata;
          we_d            = REQ_WE[win_idx];
          state_d         = S_GRANT;
        end
      end
      S_GRANT: state_d = S_CAPT;
      S_CAPT: begin
        rdata_d = BANK_RDATA;
        ack_d   = gnt_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (LOCK[owner_q]) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
          gnt_d   = '0;
          last_d  = owner_q;
          state_d = S_IDLE;
        end
      end
      S_HOLD: begin
        if (REQ[owner_q]) begin
          addr_d  = ld_addr;
          wdata_d = ld_wdata;
          we_d    = REQ_WE[owner_q];
          state_d = S_GRANT;
        end else if (!LOCK[owner_q]) begin
          gnt_d   = '0;
          last_d  = owner_q;
          state_d = S_IDLE;
        end else if (cnt_q == CW'(LOCK_MAX - 1)) begin
          gnt_d      = '0;
          last_d     = owner_q;
          lock_err_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
    if (!SYS_RST_N) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      lock_err_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      last_q     <= IW'(NREQ - 1);
      owner_q    <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      lock_err_q <= lock_err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      last_q     <= last_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
    end
  end

  assign GNT        = gnt_q;
  assign ACK        = ack_q;
  assign RDATA      = rdata_q;
  assign LOCK_ERR   = lock_err_q;
  assign BANK_ADDR  = addr_q;
  assign BANK_WDATA = wdata_q;
  assign BANK_WE    = we_q;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter: single-transaction vector table plus
// round-robin, locked burst, lock timeout and mid-transaction reset sequences.
module tb_reg_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req, req_we, lock;
  logic [27:0] req_addr;
  logic [63:0] req_wdata;
  logic [3:0]  gnt, ack;
  logic [15:0] rdata;
  logic        lock_err;
  logic [6:0]  bank_addr;
  logic [15:0] bank_wdata;
  logic        bank_we;
  logic [15:0] bank_rdata;

  logic        bd_we;
  logic [6:0]  bd_addr;
  logic [15:0] bd_data;
  logic [15:0] mem [128];

  int unsigned total = 0;
  int unsigned bad   = 0;

  reg_bank_arbiter #(.NREQ(4), .AW(7), .DW(16), .LOCK_MAX(64)) dut (
    .SYS_CLK(clk), .SYS_RST_N(rst_n), .REQ(req), .REQ_WE(req_we), .LOCK(lock),
    .REQ_ADDR(req_addr), .REQ_WDATA(req_wdata), .GNT(gnt), .ACK(ack),
    .RDATA(rdata), .LOCK_ERR(lock_err), .BANK_ADDR(bank_addr),
    .BANK_WDATA(bank_wdata), .BANK_WE(bank_we), .BANK_RDATA(bank_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: read-first, 1-cycle synchronous read, plus a preload port.
  always @(posedge clk) begin
    if (bank_we) mem[bank_addr] <= bank_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
    bank_rdata <= mem[bank_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    int unsigned rq;
    logic        we;
    logic [6:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int unsigned i, input logic w, input logic [6:0] a, input logic [15:0] d);
    req_we[i]            = w;
    req_addr[i*7 +: 7]   = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    lock  = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic preload(input logic [6:0] a, input logic [15:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  task automatic wait_ack(input int unsigned i, input int unsigned budget, input logic [3:0] gexp,
                          output bit seen, output bit gnt_ok);
    seen = 1'b0;
    gnt_ok = 1'b1;
    for (int unsigned c = 0; c < budget && !seen; c++) begin
      @(posedge clk); #1;
      if (gnt !== gexp) gnt_ok = 1'b0;
      if (ack[i]) seen = 1'b1;
    end
  endtask

  task automatic do_txn(input vec_t v);
    logic [3:0] oh;
    oh = 4'b0001 << v.rq;
    @(negedge clk);
    set_req(v.rq, v.we, v.addr, v.wdata);
    req[v.rq] = 1'b1;
    @(posedge clk); #1;
    chk("txn_gnt", 32'(gnt), 32'(oh));
    chk("txn_bank_we", 32'(bank_we), 32'(v.we));
    chk("txn_bank_addr", 32'(bank_addr), 32'(v.addr));
    if (v.we) chk("txn_bank_wdata", 32'(bank_wdata), 32'(v.wdata));
    @(posedge clk); #1;
    chk("txn_we_cleared", 32'(bank_we), 32'(0));
    chk("txn_no_early_ack", 32'(ack), 32'(0));
    @(posedge clk); #1;
    chk("txn_ack", 32'(ack), 32'(oh));
    chk("txn_rdata", 32'(rdata), 32'(v.exp_rdata));
    @(negedge clk);
    req[v.rq] = 1'b0;
  endtask

  task automatic lock_burst(input bit with3);
    bit seen, gok, hold_ok;
    do_reset();
    @(negedge clk);
    set_req(2, 1'b1, 7'h10, 16'hA010);
    lock[2] = 1'b1;
    req[2]  = 1'b1;
    @(posedge clk); #1;
    chk("lk_first_gnt", 32'(gnt), 32'(4'b0100));
    @(negedge clk);
    set_req(0, 1'b0, 7'h00, 16'h0);
    set_req(1, 1'b0, 7'h00, 16'h0);
    set_req(3, 1'b0, 7'h00, 16'h0);
    req[0] = 1'b1; req[1] = 1'b1; req[3] = with3;
    for (int unsigned k = 0; k < 3; k++) begin
      wait_ack(2, 12, 4'b0100, seen, gok);
      chk("lk_burst_ack", 32'(seen), 32'(1));
      chk("lk_burst_gnt_held", 32'(gok), 32'(1));
      @(negedge clk);
      if (k < 2) set_req(2, 1'b1, 7'(7'h11 + k), 16'(16'hA011 + k));
      else req[2] = 1'b0;
    end
    hold_ok = 1'b1;
    for (int unsigned c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (gnt !== 4'b0100) hold_ok = 1'b0;
    end
    chk("lk_hold_idle_gnt", 32'(hold_ok), 32'(1));
    @(negedge clk);
    lock[2] = 1'b0;
    @(posedge clk); #1;
    chk("lk_release_gnt", 32'(gnt), 32'(0));
    @(posedge clk); #1;
    chk("lk_next_owner", 32'(gnt), with3 ? 32'(4'b1000) : 32'(4'b0001));
    chk("lk_mem_10", 32'(mem[7'h10]), 32'h0000_A010);
    chk("lk_mem_11", 32'(mem[7'h11]), 32'h0000_A011);
    chk("lk_mem_12", 32'(mem[7'h12]), 32'h0000_A012);
  endtask

  initial begin
    bit seen, gok, early, gnt_single;
    int unsigned nack, cyc, prev;

    rst_n = 1'b0; req = '0; req_we = '0; lock = '0;
    req_addr = '0; req_wdata = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    vt[0] = '{0, 1'b1, 7'h05, 16'hBEEF, 16'h0000};
    vt[1] = '{0, 1'b0, 7'h05, 16'h0000, 16'hBEEF};
    vt[2] = '{1, 1'b1, 7'h7F, 16'hA5A5, 16'h0000};
    vt[3] = '{3, 1'b0, 7'h7F, 16'h0000, 16'hA5A5};
    vt[4] = '{2, 1'b1, 7'h05, 16'h1111, 16'hBEEF};
    vt[5] = '{1, 1'b0, 7'h05, 16'h0000, 16'h1111};
    vt[6] = '{3, 1'b1, 7'h00, 16'hFFFF, 16'h0000};
    vt[7] = '{2, 1'b0, 7'h00, 16'h0000, 16'hFFFF};

    preload(7'h05, 16'h0000);
    preload(7'h7F, 16'h0000);
    preload(7'h00, 16'h0000);
    preload(7'h20, 16'h1234);
    do_reset();
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_ack", 32'(ack), 32'(0));
    chk("rst_rdata", 32'(rdata), 32'(0));
    chk("rst_lock_err", 32'(lock_err), 32'(0));
    chk("rst_bank_addr", 32'(bank_addr), 32'(0));
    chk("rst_bank_wdata", 32'(bank_wdata), 32'(0));
    chk("rst_bank_we", 32'(bank_we), 32'(0));

    for (int unsigned v = 0; v < 8; v++) do_txn(vt[v]);

    // All four requesting continuously: grant order and ACK spacing.
    do_reset();
    @(negedge clk);
    for (int unsigned i = 0; i < 4; i++) set_req(i, 1'b0, 7'(i), 16'h0);
    req = 4'hF;
    nack = 0; cyc = 0; prev = 0; gnt_single = 1'b1;
    while (nack < 5 && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (!$onehot0(gnt)) gnt_single = 1'b0;
      if (ack != 4'b0000) begin
        chk("rr_ack_order", 32'(ack), 32'(4'b0001 << (nack % 4)));
        if (nack > 0) chk("rr_ack_gap", cyc - prev, 32'd4);
        prev = cyc;
        nack++;
      end
    end
    chk("rr_ack_count", nack, 32'd5);
    chk("rr_gnt_onehot", 32'(gnt_single), 32'(1));

    lock_burst(1'b0);
    lock_burst(1'b1);

    // Lock timeout: owner 1 holds LOCK with no REQ while 3 waits.
    do_reset();
    @(negedge clk);
    set_req(1, 1'b0, 7'h05, 16'h0);
    lock[1] = 1'b1;
    req[1]  = 1'b1;
    wait_ack(1, 10, 4'b0010, seen, gok);
    chk("to_ack", 32'(seen), 32'(1));
    @(negedge clk);
    req[1] = 1'b0;
    set_req(3, 1'b0, 7'h7F, 16'h0);
    req[3] = 1'b1;
    early = 1'b0;
    for (int unsigned n = 1; n <= 64; n++) begin
      @(posedge clk); #1;
      if (lock_err || gnt !== 4'b0010) early = 1'b1;
    end
    chk("to_no_early_release", 32'(early), 32'(0));
    @(posedge clk); #1;
    chk("to_lock_err", 32'(lock_err), 32'(1));
    chk("to_gnt_released", 32'(gnt), 32'(0));
    @(posedge clk); #1;
    chk("to_lock_err_pulse", 32'(lock_err), 32'(0));
    chk("to_next_gnt", 32'(gnt), 32'(4'b1000));

    // Reset during GRANT of a write: write must not land, pointer restarts.
    do_reset();
    do_txn('{1, 1'b0, 7'h05, 16'h0000, 16'h1111});
    @(negedge clk);
    set_req(2, 1'b1, 7'h20, 16'hDEAD);
    req[2] = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_we_before", 32'(bank_we), 32'(1));
    chk("rst_mid_addr_before", 32'(bank_addr), 32'(7'h20));
    #2;
    rst_n = 1'b0;
    req   = '0;
    #1;
    chk("rst_mid_we_async", 32'(bank_we), 32'(0));
    chk("rst_mid_gnt", 32'(gnt), 32'(0));
    chk("rst_mid_bank_addr", 32'(bank_addr), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_mem_kept", 32'(mem[7'h20]), 32'h0000_1234);
    @(negedge clk);
    set_req(0, 1'b0, 7'h20, 16'h0);
    set_req(2, 1'b0, 7'h20, 16'h0);
    req = 4'b0101;
    @(posedge clk); #1;
    chk("rst_mid_prio0", 32'(gnt), 32'(4'b0001));
    @(negedge clk);
    req[0] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    chk("rst_mid_ack", 32'(ack), 32'(4'b0001));
    chk("rst_mid_rdata", 32'(rdata), 32'h0000_1234);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
